// File: rtl/cafe_pkg.sv
// Shared encodings for the brew sequencer: FSM states, fault codes, drink codes.
package cafe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        GRIND,
        HEAT,
        POUR,
        DONE,
        FAULT
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_AGUA = 2'b01;
    localparam logic [1:0] ERR_CAFE = 2'b10;
    localparam logic [1:0] ERR_TEMP = 2'b11;

    localparam logic BEB_CAFE = 1'b0;
    localparam logic BEB_AGUA = 1'b1;

endpackage

// File: rtl/cafe_brew_timer.sv
// Phase timer: counts while enabled, clears on request, flags when count equals limit.
module cafe_brew_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    // Clear has priority so every phase starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/cafe_brew_sequencer.sv
// Brew sequencer: check -> grind (coffee only) -> heat -> pour, with latched fault codes.
module cafe_brew_sequencer
    import cafe_pkg::*;
#(
    parameter int GRIND_CYC    = 8,
    parameter int HEAT_TIMEOUT = 32,
    parameter int POUR_CAFE    = 16,
    parameter int POUR_AGUA    = 12,
    parameter int CNT_W        = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       drink,
    input  logic       ha,
    input  logic       hc,
    input  logic       temp_ok,
    input  logic       clr_err,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       grind,
    output logic       heat,
    output logic       pump
);

    state_t           state;
    state_t           state_n;
    logic [1:0]       code_n;
    logic             drink_q;
    logic             tmr_en;
    logic             tmr_clr;
    logic             tmr_hit;
    logic [CNT_W-1:0] tmr_limit;

    // Terminal count for the phase currently running.
    always_comb begin
        tmr_limit = '0;
        case (state)
            GRIND:   tmr_limit = CNT_W'(GRIND_CYC - 1);
            HEAT:    tmr_limit = CNT_W'(HEAT_TIMEOUT - 1);
            POUR:    tmr_limit = (drink_q == BEB_AGUA) ? CNT_W'(POUR_AGUA - 1)
                                                       : CNT_W'(POUR_CAFE - 1);
            default: tmr_limit = '0;
        endcase
    end

    // Counter restarts on every state change and runs only in timed phases.
    assign tmr_clr = (state_n != state);
    assign tmr_en  = (state == GRIND) || (state == HEAT) || (state == POUR);

    cafe_brew_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .hit   (tmr_hit)
    );

    // Next state and fault code; water loss outranks coffee loss outranks timeout.
    always_comb begin
        state_n = state;
        code_n  = err_code;
        case (state)
            IDLE: begin
                if (start) state_n = CHECK;
            end
            CHECK: begin
                if (!ha) begin
                    state_n = FAULT; code_n = ERR_AGUA;
                end else if (drink_q == BEB_CAFE && !hc) begin
                    state_n = FAULT; code_n = ERR_CAFE;
                end else if (drink_q == BEB_CAFE) begin
                    state_n = GRIND;
                end else begin
                    state_n = HEAT;
                end
            end
            GRIND: begin
                if (!ha) begin
                    state_n = FAULT; code_n = ERR_AGUA;
                end else if (!hc) begin
                    state_n = FAULT; code_n = ERR_CAFE;
                end else if (tmr_hit) begin
                    state_n = HEAT;
                end
            end
            HEAT: begin
                if (!ha) begin
                    state_n = FAULT; code_n = ERR_AGUA;
                end else if (temp_ok) begin
                    state_n = POUR;
                end else if (tmr_hit) begin
                    state_n = FAULT; code_n = ERR_TEMP;
                end
            end
            POUR: begin
                if (!ha) begin
                    state_n = FAULT; code_n = ERR_AGUA;
                end else if (tmr_hit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            FAULT: begin
                if (clr_err) begin
                    state_n = IDLE; code_n = ERR_NONE;
                end
            end
            default: begin
                state_n = IDLE; code_n = ERR_NONE;
            end
        endcase
    end

    // State, fault code and drink selection registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            err_code <= ERR_NONE;
            drink_q  <= BEB_CAFE;
        end else begin
            state    <= state_n;
            err_code <= code_n;
            if (state == IDLE && start) drink_q <= drink;
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        grind = 1'b0;
        heat  = 1'b0;
        pump  = 1'b0;
        case (state)
            CHECK: busy = 1'b1;
            GRIND: begin busy = 1'b1; grind = 1'b1; end
            HEAT:  begin busy = 1'b1; heat = 1'b1; end
            POUR:  begin busy = 1'b1; heat = 1'b1; pump = 1'b1; end
            DONE:  done = 1'b1;
            FAULT: err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cafe_brew_sequencer.sv
// Bench for cafe_brew_sequencer: directed and random scenarios against an event-timeline model.
module tb_cafe_brew_sequencer;

    localparam int G = 8, HT = 32, PC = 16, PA = 12, N = 100, NONE = 999;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, drink = 1'b0, ha = 1'b1, hc = 1'b1;
    logic temp_ok = 1'b1, clr_err = 1'b0;
    logic busy, done, err, grind, heat, pump;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    cafe_brew_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .drink(drink), .ha(ha), .hc(hc),
        .temp_ok(temp_ok), .clr_err(clr_err), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .grind(grind), .heat(heat), .pump(pump)
    );

    // Per-cycle stimulus (index k = cycle after edge Ek) and observed outputs
    logic ha_a[N], hc_a[N], tp_a[N], st_a[N], dr_a[N], cl_a[N];
    logic [7:0] obs[N];   // {busy,done,err,err_code[1:0],grind,heat,pump}

    logic drink_m;
    int heat_s, pour_s, done_t, fault_t, clr_t, run_n;
    logic [1:0] fault_c;
    int cmp = 0, errs = 0;

    task automatic fill(input logic d, input int hadrop, input int hcdrop, input int trise);
        drink_m = d;
        for (int k = 0; k < N; k++) begin
            ha_a[k] = (k < hadrop);
            hc_a[k] = (k < hcdrop);
            tp_a[k] = (k >= trise);
            st_a[k] = 1'b0;
            cl_a[k] = 1'b0;
            dr_a[k] = 1'($urandom_range(0, 1));
        end
    endtask

    // Timeline model: phase boundaries from drink and temp rise, then the earliest
    // violated condition (water over the whole run, coffee until heat, timeout).
    task automatic model(input int clr_delay, input bit rnd_start);
        int to_t, ft, lim;
        logic [1:0] fc;
        heat_s = drink_m ? 1 : 1 + G;
        to_t   = heat_s + HT;
        pour_s = -1;
        for (int k = heat_s; k < heat_s + HT; k++)
            if (tp_a[k]) begin pour_s = k + 1; break; end
        done_t = (pour_s < 0) ? NONE : pour_s + (drink_m ? PA : PC);
        ft = NONE; fc = 2'b00;
        if (pour_s < 0) begin ft = to_t; fc = 2'b11; end
        if (!drink_m)
            for (int k = 0; k < heat_s; k++)
                if (!hc_a[k]) begin
                    if (k + 1 <= ft) begin ft = k + 1; fc = 2'b10; end
                    break;
                end
        lim = (pour_s < 0) ? to_t : done_t;
        for (int k = 0; k < lim; k++)
            if (!ha_a[k]) begin
                if (k + 1 <= ft) begin ft = k + 1; fc = 2'b01; end
                break;
            end
        fault_t = ft; fault_c = fc;
        clr_t = (ft == NONE) ? NONE : ft + clr_delay;
        if (ft != NONE) cl_a[clr_t] = 1'b1;
        run_n = (ft == NONE) ? done_t + 3 : clr_t + 3;
        for (int k = 0; k < N; k++)
            if (k <= done_t && k <= clr_t) st_a[k] = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    function automatic logic [7:0] exp_out(input int k);
        if (fault_t != NONE && k >= fault_t)
            return (k <= clr_t) ? {3'b001, fault_c, 3'b000} : 8'h00;
        if (k > done_t)  return 8'h00;
        if (k == done_t) return 8'b0100_0000;
        if (k == 0)      return 8'b1000_0000;
        if (k < heat_s)  return 8'b1000_0100;
        if (pour_s < 0 || k < pour_s) return 8'b1000_0010;
        return 8'b1000_0011;
    endfunction

    // Called just after a rising edge with the DUT idle.
    task automatic run_seq(input int n);
        start = 1'b1; drink = drink_m;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            ha = ha_a[k]; hc = hc_a[k]; temp_ok = tp_a[k];
            start = st_a[k]; drink = dr_a[k]; clr_err = cl_a[k];
            @(negedge clk);
            obs[k] = {busy, done, err, err_code, grind, heat, pump};
            @(posedge clk); #1;
        end
        ha = 1'b1; hc = 1'b1; temp_ok = 1'b1; start = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp++;
        if ({busy, done, err, err_code, grind, heat, pump} !== 8'h00) begin
            errs++; $display("FAIL reset outputs: got %b want 00000000", {busy, done, err, err_code, grind, heat, pump});
        end
        @(posedge clk); #1; start = 1'b0; rst = 1'b1;
        @(negedge clk);
        cmp++;
        if ({busy, done, err, err_code, grind, heat, pump} !== 8'h00) begin
            errs++; $display("FAIL idle outputs: got %b want 00000000", {busy, done, err, err_code, grind, heat, pump});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_coffee();
        int g, p, d;
        fill(1'b0, N, N, 0); model(0, 1'b1); run_seq(run_n);
        g = 0; p = 0; d = -1;
        for (int k = 0; k < run_n; k++) begin
            cmp++;
            if (obs[k] !== exp_out(k)) begin
                errs++; $display("FAIL coffee cyc %0d: got %b want %b", k, obs[k], exp_out(k));
            end
            g += obs[k][2]; p += obs[k][0];
            if (obs[k][6] && d < 0) d = k;
        end
        cmp++; if (g != 8)  begin errs++; $display("FAIL coffee grind count: got %0d want 8", g); end
        cmp++; if (p != 16) begin errs++; $display("FAIL coffee pump count: got %0d want 16", p); end
        cmp++; if (d != 26) begin errs++; $display("FAIL coffee done cycle: got %0d want 26", d); end
    endtask

    task automatic test_water();
        int g, p, d;
        fill(1'b1, N, 0, 0); model(0, 1'b1); run_seq(run_n);
        g = 0; p = 0; d = -1;
        for (int k = 0; k < run_n; k++) begin
            cmp++;
            if (obs[k] !== exp_out(k)) begin
                errs++; $display("FAIL water cyc %0d: got %b want %b", k, obs[k], exp_out(k));
            end
            g += obs[k][2]; p += obs[k][0];
            if (obs[k][6] && d < 0) d = k;
        end
        cmp++; if (g != 0)  begin errs++; $display("FAIL water grind count: got %0d want 0", g); end
        cmp++; if (p != 12) begin errs++; $display("FAIL water pump count: got %0d want 12", p); end
        cmp++; if (d != 14) begin errs++; $display("FAIL water done cycle: got %0d want 14", d); end
    endtask

    task automatic test_no_coffee();
        fill(1'b0, N, 0, 0); model(4, 1'b1); run_seq(run_n);
        for (int k = 0; k < run_n; k++) begin
            cmp++;
            if (obs[k] !== exp_out(k)) begin
                errs++; $display("FAIL nocafe cyc %0d: got %b want %b", k, obs[k], exp_out(k));
            end
        end
        cmp++;
        if (obs[1] !== 8'b0011_0000) begin
            errs++; $display("FAIL nocafe fault entry: got %b want 00110000", obs[1]);
        end
    endtask

    task automatic test_timeout();
        int h;
        fill(1'b1, N, N, N); model(5, 1'b0);
        for (int k = fault_t; k <= clr_t; k++) st_a[k] = 1'b1;
        run_seq(run_n);
        h = 0;
        for (int k = 0; k < run_n; k++) begin
            cmp++;
            if (obs[k] !== exp_out(k)) begin
                errs++; $display("FAIL timeout cyc %0d: got %b want %b", k, obs[k], exp_out(k));
            end
            h += obs[k][1];
        end
        cmp++; if (h != 32) begin errs++; $display("FAIL timeout heat count: got %0d want 32", h); end
        cmp++;
        if (obs[33] !== 8'b0011_1000) begin
            errs++; $display("FAIL timeout fault code: got %b want 00111000", obs[33]);
        end
    endtask

    task automatic test_water_loss();
        // Water lost on the 5th pour cycle of a hot-water run.
        fill(1'b1, 6, N, 0); model(2, 1'b0); run_seq(run_n);
        for (int k = 0; k < run_n; k++) begin
            cmp++;
            if (obs[k] !== exp_out(k)) begin
                errs++; $display("FAIL pourloss cyc %0d: got %b want %b", k, obs[k], exp_out(k));
            end
        end
        cmp++;
        if (obs[7] !== 8'b0010_1000) begin
            errs++; $display("FAIL pourloss fault: got %b want 00101000", obs[7]);
        end
        // Water and coffee lost together mid-grind: water code wins.
        fill(1'b0, 4, 4, 0); model(3, 1'b1); run_seq(run_n);
        for (int k = 0; k < run_n; k++) begin
            cmp++;
            if (obs[k] !== exp_out(k)) begin
                errs++; $display("FAIL prio cyc %0d: got %b want %b", k, obs[k], exp_out(k));
            end
        end
        cmp++;
        if (obs[5] !== 8'b0010_1000) begin
            errs++; $display("FAIL prio fault: got %b want 00101000", obs[5]);
        end
    endtask

    task automatic test_reset_mid_pour();
        int d;
        fill(1'b0, N, N, 0); model(0, 1'b0); run_seq(16);
        cmp++;
        if (obs[15] !== 8'b1000_0011) begin
            errs++; $display("FAIL midpour pre-reset: got %b want 10000011", obs[15]);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        cmp++;
        if ({busy, done, err, err_code, grind, heat, pump} !== 8'h00) begin
            errs++; $display("FAIL midpour reset: got %b want 00000000", {busy, done, err, err_code, grind, heat, pump});
        end
        @(posedge clk); #1; rst = 1'b1;
        fill(1'b1, N, N, 0); model(0, 1'b0); run_seq(run_n);
        d = -1;
        for (int k = 0; k < run_n; k++) begin
            cmp++;
            if (obs[k] !== exp_out(k)) begin
                errs++; $display("FAIL postreset cyc %0d: got %b want %b", k, obs[k], exp_out(k));
            end
            if (obs[k][6] && d < 0) d = k;
        end
        cmp++; if (d != 14) begin errs++; $display("FAIL postreset done cycle: got %0d want 14", d); end
    endtask

    task automatic test_random();
        int hd, cd, tr;
        for (int it = 0; it < 40; it++) begin
            hd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 50)) : N;
            cd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : N;
            tr = $urandom_range(0, 45);
            fill(1'($urandom_range(0, 1)), hd, cd, tr);
            model($urandom_range(0, 4), 1'b1);
            run_seq(run_n);
            for (int k = 0; k < run_n; k++) begin
                cmp++;
                if (obs[k] !== exp_out(k)) begin
                    errs++; $display("FAIL random it %0d cyc %0d: got %b want %b", it, k, obs[k], exp_out(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_coffee();
        test_water();
        test_no_coffee();
        test_timeout();
        test_water_loss();
        test_reset_mid_pour();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
